// File: rtl/puc_cpu_pkg.sv
// Shared definitions for the PUC CPU core: opcodes, core states, fault codes
// and instruction field positions.
package puc_cpu_pkg;

  typedef enum logic [4:0] {
    OP_NOP        = 5'd0,
    OP_ADD        = 5'd1,
    OP_LOAD       = 5'd2,
    OP_JUMP       = 5'd3,
    OP_RESET      = 5'd4,
    OP_INC        = 5'd5,
    OP_DEC        = 5'd6,
    OP_LOADSWITCH = 5'd7,
    OP_CALL       = 5'd8,
    OP_RET        = 5'd9,
    OP_IF0JUMP    = 5'd10,
    OP_IF1JUMP    = 5'd11,
    OP_LSHIFT     = 5'd12,
    OP_RSHIFT     = 5'd13,
    OP_HALT       = 5'd14
  } opcode_t;

  typedef enum logic [1:0] {
    STATE_RUN    = 2'd0,
    STATE_HALTED = 2'd1,
    STATE_FAULT  = 2'd2
  } cpuState_t;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL   = 2'd3;

  localparam int unsigned OPCODE_MSB = 28;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned SRC1_MSB   = 23;
  localparam int unsigned SRC1_LSB   = 16;
  localparam int unsigned SRC2_MSB   = 15;
  localparam int unsigned SRC2_LSB   = 8;
  localparam int unsigned DST_MSB    = 7;
  localparam int unsigned DST_LSB    = 0;

endpackage

// File: rtl/puc_return_stack.sv
// Return-address LIFO for CALL/RET.
// Ports: clock, isReset (sync, active-high), push/pop/clear requests, pushData,
// top (entry at top of stack), depth (live entries), full, empty.
// Push is ignored when full and pop when empty; the core checks full/empty
// itself so it can raise a fault instead.
module puc_return_stack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clock,
  input  logic                    isReset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   pushData,
  output logic [DATA_WIDTH-1:0]   top,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned DEPTH_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] entries [DEPTH];

  assign full  = (depth == DEPTH_WIDTH'(DEPTH));
  assign empty = (depth == '0);
  // Top entry sits one below the depth count; value is meaningless when empty.
  assign top   = entries[PTR_WIDTH'(depth - DEPTH_WIDTH'(1))];

  // Occupancy counter.
  always_ff @(posedge clock) begin
    if (isReset || clear) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEPTH_WIDTH'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_WIDTH'(1);
    end
  end

  // Storage needs no reset; contents are only read below the depth count.
  always_ff @(posedge clock) begin
    if (!isReset && !clear && push && !full) begin
      entries[depth[PTR_WIDTH-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/puc_cpu_core.sv
// PUC CPU core: single-issue, one instruction per clock, with RUN/HALTED/FAULT
// control, a return stack and a debug register read port.
// Ports: clock, isReset (sync, active-high), instruction (word at pc), switch,
// resume (leave HALTED), debugIndex; pc, register1Value (LED drive),
// debugValue (combinational register read), halted, fault, faultCode,
// stackDepth.
module puc_cpu_core
  import puc_cpu_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned NUM_REGISTERS  = 8,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned STACK_DEPTH    = 16,
  parameter int unsigned SWITCH_WIDTH   = 1
) (
  input  logic                          clock,
  input  logic                          isReset,
  input  logic [31:0]                   instruction,
  input  logic [SWITCH_WIDTH-1:0]       switch,
  input  logic                          resume,
  input  logic [2:0]                    debugIndex,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [REGISTER_WIDTH-1:0]     register1Value,
  output logic [REGISTER_WIDTH-1:0]     debugValue,
  output logic                          halted,
  output logic                          fault,
  output logic [1:0]                    faultCode,
  output logic [$clog2(STACK_DEPTH):0]  stackDepth
);

  localparam int unsigned REG_IDX_WIDTH = $clog2(NUM_REGISTERS);

  cpuState_t state;
  logic [REGISTER_WIDTH-1:0] regFile [NUM_REGISTERS];

  opcode_t                   opcode;
  logic [7:0]                src1Field, src2Field, dstField;
  logic [REG_IDX_WIDTH-1:0]  src1Idx, src2Idx, dstIdx;
  logic [REGISTER_WIDTH-1:0] src1Value, src2Value, aluResult;
  logic [PC_WIDTH-1:0]       nextPc, jumpTarget, stackTop;
  logic                      writeEnable, pushReq, popReq, clearReq;
  logic                      faultReq, haltReq, runActive, stackFull, stackEmpty;
  logic [1:0]                faultCodeReq;
  logic                      unusedBits;

  assign opcode     = opcode_t'(instruction[OPCODE_MSB:OPCODE_LSB]);
  assign src1Field  = instruction[SRC1_MSB:SRC1_LSB];
  assign src2Field  = instruction[SRC2_MSB:SRC2_LSB];
  assign dstField   = instruction[DST_MSB:DST_LSB];
  assign src1Idx    = src1Field[REG_IDX_WIDTH-1:0];
  assign src2Idx    = src2Field[REG_IDX_WIDTH-1:0];
  assign dstIdx     = dstField[REG_IDX_WIDTH-1:0];
  assign src1Value  = regFile[src1Idx];
  assign src2Value  = regFile[src2Idx];
  assign jumpTarget = PC_WIDTH'(src2Field);
  assign unusedBits = ^{instruction[31:29], src1Field, src2Field, dstField};

  assign register1Value = regFile[1];

  // Debug read; indices beyond the register file read as zero.
  always_comb begin
    debugValue = '0;
    if (32'(debugIndex) < NUM_REGISTERS) begin
      debugValue = regFile[debugIndex[REG_IDX_WIDTH-1:0]];
    end
  end

  // Instruction decode, ALU and next-pc selection for the RUN state.
  always_comb begin
    aluResult    = '0;
    writeEnable  = 1'b0;
    nextPc       = pc + PC_WIDTH'(1);
    pushReq      = 1'b0;
    popReq       = 1'b0;
    clearReq     = 1'b0;
    faultReq     = 1'b0;
    faultCodeReq = FAULT_NONE;
    haltReq      = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD:        begin aluResult = src1Value + src2Value;              writeEnable = 1'b1; end
      OP_LOAD:       begin aluResult = REGISTER_WIDTH'(src2Field);         writeEnable = 1'b1; end
      OP_INC:        begin aluResult = src1Value + REGISTER_WIDTH'(1);     writeEnable = 1'b1; end
      OP_DEC:        begin aluResult = src1Value - REGISTER_WIDTH'(1);     writeEnable = 1'b1; end
      OP_LOADSWITCH: begin aluResult = REGISTER_WIDTH'(switch);            writeEnable = 1'b1; end
      OP_LSHIFT:     begin aluResult = src1Value << 1;                     writeEnable = 1'b1; end
      OP_RSHIFT:     begin aluResult = src1Value >> 1;                     writeEnable = 1'b1; end
      OP_JUMP:       nextPc = jumpTarget;
      OP_RESET:      begin nextPc = '0; clearReq = 1'b1; end
      OP_IF0JUMP:    if (src1Value == '0) nextPc = jumpTarget;
      OP_IF1JUMP:    if (src1Value != '0) nextPc = jumpTarget;
      OP_HALT:       haltReq = 1'b1;
      OP_CALL: begin
        if (stackFull) begin
          faultReq     = 1'b1;
          faultCodeReq = FAULT_OVERFLOW;
        end else begin
          pushReq = 1'b1;
          nextPc  = jumpTarget;
        end
      end
      OP_RET: begin
        if (stackEmpty) begin
          faultReq     = 1'b1;
          faultCodeReq = FAULT_UNDERFLOW;
        end else begin
          popReq = 1'b1;
          nextPc = stackTop;
        end
      end
      default: begin
        faultReq     = 1'b1;
        faultCodeReq = FAULT_ILLEGAL;
      end
    endcase
  end

  // Stack only moves for an instruction actually executing in RUN.
  assign runActive = (state == STATE_RUN) && !isReset;

  puc_return_stack #(
    .DATA_WIDTH (PC_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) returnStack (
    .clock    (clock),
    .isReset  (isReset),
    .push     (runActive && pushReq),
    .pop      (runActive && popReq),
    .clear    (runActive && clearReq),
    .pushData (pc + PC_WIDTH'(1)),
    .top      (stackTop),
    .depth    (stackDepth),
    .full     (stackFull),
    .empty    (stackEmpty)
  );

  // Control state machine plus pc and register file updates.
  always_ff @(posedge clock) begin
    if (isReset) begin
      state     <= STATE_RUN;
      pc        <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      faultCode <= FAULT_NONE;
      for (int i = 0; i < NUM_REGISTERS; i++) regFile[i] <= '0;
    end else begin
      case (state)
        STATE_RUN: begin
          if (faultReq) begin
            state     <= STATE_FAULT;
            fault     <= 1'b1;
            faultCode <= faultCodeReq;
          end else if (haltReq) begin
            state  <= STATE_HALTED;
            halted <= 1'b1;
          end else begin
            pc <= nextPc;
            if (writeEnable && dstIdx != '0) regFile[dstIdx] <= aluResult;
          end
        end
        STATE_HALTED: begin
          if (resume) begin
            state  <= STATE_RUN;
            halted <= 1'b0;
            pc     <= pc + PC_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puc_cpu_core.sv
// Self-checking bench for puc_cpu_core: directed scenarios followed by random
// instruction streams, all compared against a behavioural model each cycle.
module tb_puc_cpu_core;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        isReset = 1'b1;
  logic [31:0] instruction = '0;
  logic [0:0]  switch = '0;
  logic        resume = 1'b0;
  logic [2:0]  debugIndex = '0;
  logic [7:0]  pc;
  logic [7:0]  register1Value;
  logic [7:0]  debugValue;
  logic        halted;
  logic        fault;
  logic [1:0]  faultCode;
  logic [2:0]  stackDepth;

  int testCount = 0;
  int failCount = 0;

  // Model state: 0 run, 1 halted, 2 fault.
  int mPc;
  int mRegs [8];
  int mStack [$];
  int mState;
  int mFaultCode;

  puc_cpu_core #(
    .REGISTER_WIDTH (8),
    .NUM_REGISTERS  (8),
    .PC_WIDTH       (8),
    .STACK_DEPTH    (DEPTH),
    .SWITCH_WIDTH   (1)
  ) dut (
    .clock          (clock),
    .isReset        (isReset),
    .instruction    (instruction),
    .switch         (switch),
    .resume         (resume),
    .debugIndex     (debugIndex),
    .pc             (pc),
    .register1Value (register1Value),
    .debugValue     (debugValue),
    .halted         (halted),
    .fault          (fault),
    .faultCode      (faultCode),
    .stackDepth     (stackDepth)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d);
    return {3'b000, 5'(op), 8'(s1), 8'(s2), 8'(d)};
  endfunction

  function automatic void writeReg(input int d, input int v);
    if (d != 0) mRegs[d] = v % 256;
  endfunction

  function automatic void modelStep(input logic [31:0] instr, input int sw, input bit res, input bit rst);
    int op, s1, s2, d, imm, nxt;
    op  = int'(instr[28:24]);
    s1  = int'(instr[18:16]);
    s2  = int'(instr[10:8]);
    imm = int'(instr[15:8]);
    d   = int'(instr[2:0]);
    nxt = (mPc + 1) % 256;
    if (rst) begin
      mPc = 0; mState = 0; mFaultCode = 0;
      mStack.delete();
      foreach (mRegs[i]) mRegs[i] = 0;
    end else if (mState == 1) begin
      if (res) begin mState = 0; mPc = nxt; end
    end else if (mState == 0) begin
      if (op > 14) begin
        mState = 2; mFaultCode = 3;
      end else if (op == 8 && mStack.size() == DEPTH) begin
        mState = 2; mFaultCode = 1;
      end else if (op == 9 && mStack.size() == 0) begin
        mState = 2; mFaultCode = 2;
      end else begin
        case (op)
          1:  begin writeReg(d, mRegs[s1] + mRegs[s2]); mPc = nxt; end
          2:  begin writeReg(d, imm); mPc = nxt; end
          3:  mPc = imm;
          4:  begin mPc = 0; mStack.delete(); end
          5:  begin writeReg(d, mRegs[s1] + 1); mPc = nxt; end
          6:  begin writeReg(d, mRegs[s1] + 255); mPc = nxt; end
          7:  begin writeReg(d, sw); mPc = nxt; end
          8:  begin mStack.push_back(nxt); mPc = imm; end
          9:  mPc = mStack.pop_back();
          10: mPc = (mRegs[s1] == 0) ? imm : nxt;
          11: mPc = (mRegs[s1] != 0) ? imm : nxt;
          12: begin writeReg(d, mRegs[s1] * 2); mPc = nxt; end
          13: begin writeReg(d, mRegs[s1] / 2); mPc = nxt; end
          14: mState = 1;
          default: mPc = nxt;
        endcase
      end
    end
  endfunction

  task automatic checkAll();
    checkValue("pc", 32'(pc), 32'(mPc));
    checkValue("register1Value", 32'(register1Value), 32'(mRegs[1]));
    checkValue("debugValue", 32'(debugValue), 32'(mRegs[debugIndex]));
    checkValue("halted", 32'(halted), 32'(mState == 1));
    checkValue("fault", 32'(fault), 32'(mState == 2));
    checkValue("faultCode", 32'(faultCode), 32'(mFaultCode));
    checkValue("stackDepth", 32'(stackDepth), 32'(mStack.size()));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic [31:0] instr, input int sw = 0, input bit res = 0, input bit rst = 0);
    instruction = instr;
    switch      = sw[0];
    resume      = res;
    isReset     = rst;
    debugIndex  = 3'($urandom_range(0, 7));
    @(posedge clock);
    modelStep(instr, sw, res, rst);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    step(mk(0, 0, 0, 0), 0, 0, 1);
  endtask

  initial begin
    mPc = 0; mState = 0; mFaultCode = 0;
    foreach (mRegs[i]) mRegs[i] = 0;

    doReset();
    doReset();
    checkValue("reset_pc", 32'(pc), 0);

    // Arithmetic and wrap.
    step(mk(2, 0, 5, 1));
    step(mk(2, 0, 3, 2));
    step(mk(1, 1, 2, 1));
    checkValue("add_result", 32'(register1Value), 8);
    checkValue("add_pc", 32'(pc), 3);
    step(mk(2, 0, 250, 1));
    step(mk(2, 0, 10, 2));
    step(mk(1, 1, 2, 1));
    checkValue("add_wrap", 32'(register1Value), 4);

    // Conditional jumps.
    step(mk(7, 0, 0, 1), 1);
    step(mk(11, 1, 8'h20, 0));
    checkValue("if1_taken", 32'(pc), 32'h20);
    step(mk(2, 0, 0, 1));
    step(mk(11, 1, 8'h60, 0));
    checkValue("if1_not_taken", 32'(pc), 32'h22);
    step(mk(10, 1, 8'h40, 0));
    checkValue("if0_taken", 32'(pc), 32'h40);
    step(mk(7, 0, 0, 1), 1);
    step(mk(10, 1, 8'h70, 0));
    checkValue("if0_not_taken", 32'(pc), 32'h42);

    // Nested calls and returns.
    doReset();
    for (int i = 1; i <= DEPTH; i++) step(mk(8, 0, i * 16, 0));
    checkValue("call_depth_full", 32'(stackDepth), DEPTH);
    for (int i = 0; i < DEPTH; i++) step(mk(9, 0, 0, 0));
    checkValue("ret_pc", 32'(pc), 1);
    checkValue("ret_depth", 32'(stackDepth), 0);
    step(mk(9, 0, 0, 0));
    checkValue("underflow_code", 32'(faultCode), 2);
    checkValue("underflow_pc", 32'(pc), 1);
    step(mk(0, 0, 0, 0), 0, 1);
    checkValue("fault_ignores_resume", 32'(fault), 1);
    doReset();
    for (int i = 1; i <= DEPTH; i++) step(mk(8, 0, i * 16, 0));
    step(mk(8, 0, 8'h99, 0));
    checkValue("overflow_code", 32'(faultCode), 1);
    checkValue("overflow_pc", 32'(pc), 32'h40);
    doReset();
    step(mk(20, 0, 0, 0));
    checkValue("illegal_code", 32'(faultCode), 3);
    doReset();
    checkValue("fault_cleared", 32'(fault), 0);

    // Halt and resume.
    for (int i = 0; i < 7; i++) step(mk(0, 0, 0, 0));
    step(mk(14, 0, 0, 0));
    for (int i = 0; i < 10; i++) step(mk(2, 0, 99, 1));
    checkValue("halt_pc", 32'(pc), 7);
    checkValue("halt_no_write", 32'(register1Value), 0);
    step(mk(0, 0, 0, 0), 0, 1);
    checkValue("resume_pc", 32'(pc), 8);
    checkValue("resume_halted", 32'(halted), 0);

    // Reset priority.
    step(mk(2, 0, 7, 1));
    step(mk(8, 0, 8'h30, 0), 0, 0, 1);
    checkValue("reset_mid_call_depth", 32'(stackDepth), 0);
    step(mk(2, 0, 7, 1));
    step(mk(14, 0, 0, 0));
    step(mk(0, 0, 0, 0), 0, 1, 1);
    checkValue("reset_vs_resume_pc", 32'(pc), 0);
    checkValue("reset_clears_r1", 32'(register1Value), 0);
    step(mk(2, 0, 8'h55, 0));
    debugIndex = 3'd0;
    #1;
    checkValue("dst0_discard", 32'(debugValue), 0);

    // Random instruction streams.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] instr;
      int op;
      bit rst;
      op = ($urandom_range(0, 99) < 4) ? int'($urandom_range(15, 31)) : int'($urandom_range(0, 14));
      instr = $urandom;
      instr[28:24] = 5'(op);
      rst = (mState == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      step(instr, int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rst);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
